// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: default DM widths, the
// owner encoding of an issued command and the starvation counter width.
package dm_pkg;

    localparam int DMA_SIZE_DEF = 3;
    localparam int DMD_SIZE_DEF = 4;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/dm_starve_ctr.sv
// Saturating up-counter counting consecutive host denials; clr takes
// precedence over inc and the count never passes limit.
module dm_starve_ctr
    import dm_pkg::*;
#(
    parameter int W = STARVE_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single DM port: core has priority, the host
// is guaranteed a slot after STARVE_MAX consecutive denials.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DMA_SIZE   = DMA_SIZE_DEF,
    parameter int DMD_SIZE   = DMD_SIZE_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    output logic                core_stall,
    output logic                core_rvalid,
    input  logic                hst_req,
    input  logic                hst_wrb,
    input  logic [DMA_SIZE-1:0] hst_add,
    input  logic [DMD_SIZE-1:0] hst_wdata,
    output logic                hst_gnt,
    output logic                hst_rvalid,
    output logic [DMD_SIZE-1:0] hst_rdata,
    output logic                m_dm_cslt,
    output logic                m_dm_wrb,
    output logic [DMA_SIZE-1:0] m_dm_add,
    output logic [DMD_SIZE-1:0] m_bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    // Handshake: a host command (hst_req with wrb/add/wdata) is held stable
    // until the cycle hst_gnt=1, which is the cycle it is issued to DM; a core
    // command issues on any cycle with ps_dm_cslt=1 and core_stall=0, and is
    // otherwise held by the core. Read data returns one cycle after issue on
    // the matching rvalid; write data moves to DM one cycle after issue.
    logic                    host_win;
    logic                    at_limit;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    logic                    wr_pend;
    owner_e                  wr_own;
    logic [DMD_SIZE-1:0]     wdata_q;
    logic                    rd_pend;
    owner_e                  rd_own;
    logic [DMD_SIZE-1:0]     hst_rdata_q;

    dm_starve_ctr #(.W(STARVE_CNT_W)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (hst_req & ~host_win),
        .clr      (host_win | ~hst_req),
        .limit    (STARVE_LIMIT),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        host_win   = hst_req & (~ps_dm_cslt | at_limit);
        hst_gnt    = host_win & ~reset;
        core_stall = hst_gnt & ps_dm_cslt;
        m_dm_cslt  = ~reset & (host_win | ps_dm_cslt);
        m_dm_wrb   = host_win ? hst_wrb : ps_dm_wrb;
        m_dm_add   = host_win ? hst_add : dg_dm_add;
        // Outside a host write phase the core data passes straight through.
        if (reset) begin
            m_bc_dt = '0;
        end else if (wr_pend && (wr_own == OWN_HOST)) begin
            m_bc_dt = wdata_q;
        end else begin
            m_bc_dt = bc_dt;
        end
    end

    assign hst_rvalid  = rd_pend & (rd_own == OWN_HOST);
    assign core_rvalid = rd_pend & (rd_own == OWN_CORE);
    assign hst_rdata   = hst_rvalid ? dm_bc_dt : hst_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend     <= 1'b0;
            wr_own      <= OWN_CORE;
            wdata_q     <= '0;
            rd_pend     <= 1'b0;
            rd_own      <= OWN_CORE;
            hst_rdata_q <= '0;
        end else begin
            wr_pend <= m_dm_cslt & m_dm_wrb;
            wr_own  <= host_win ? OWN_HOST : OWN_CORE;
            rd_pend <= m_dm_cslt & ~m_dm_wrb;
            rd_own  <= host_win ? OWN_HOST : OWN_CORE;
            if (host_win && hst_wrb) begin
                wdata_q <= hst_wdata;
            end
            if (hst_rvalid) begin
                hst_rdata_q <= dm_bc_dt;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a small DM model with write-to-read
// bypass, a transaction-level reference model, directed and random scenarios.
module tb_dm_arbiter;

    localparam int AW   = 3;
    localparam int DW   = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ps_dm_cslt, ps_dm_wrb;
    logic [AW-1:0] dg_dm_add;
    logic [DW-1:0] bc_dt;
    logic          core_stall, core_rvalid;
    logic          hst_req, hst_wrb;
    logic [AW-1:0] hst_add;
    logic [DW-1:0] hst_wdata;
    logic          hst_gnt, hst_rvalid;
    logic [DW-1:0] hst_rdata;
    logic          m_dm_cslt, m_dm_wrb;
    logic [AW-1:0] m_dm_add;
    logic [DW-1:0] m_bc_dt;
    logic [DW-1:0] dm_bc_dt;

    int errors = 0;
    int checks = 0;

    dm_arbiter #(.DMA_SIZE(AW), .DMD_SIZE(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add), .bc_dt(bc_dt),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .hst_req(hst_req), .hst_wrb(hst_wrb), .hst_add(hst_add), .hst_wdata(hst_wdata),
        .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid), .hst_rdata(hst_rdata),
        .m_dm_cslt(m_dm_cslt), .m_dm_wrb(m_dm_wrb), .m_dm_add(m_dm_add), .m_bc_dt(m_bc_dt),
        .dm_bc_dt(dm_bc_dt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 5 + 3);
    endfunction

    // ---------------- DM model (write lands the cycle after its command) ----------------
    logic [DW-1:0] tmem [8];
    logic          mem_load;
    logic          mp_wr;
    logic [AW-1:0] mp_addr;
    logic [DW-1:0] rd_q;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) tmem[i] <= pat(i);
            mp_wr <= 1'b0;
            rd_q  <= '0;
        end else if (reset) begin
            mp_wr <= 1'b0;
        end else begin
            if (mp_wr) tmem[mp_addr] <= m_bc_dt;
            if (m_dm_cslt && !m_dm_wrb)
                rd_q <= (mp_wr && mp_addr == m_dm_add) ? m_bc_dt : tmem[m_dm_add];
            mp_wr   <= m_dm_cslt && m_dm_wrb;
            mp_addr <= m_dm_add;
        end
    end
    assign dm_bc_dt = rd_q;

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] ref_mem [8];
    int            starve;
    bit            wp_v, wp_host;
    logic [AW-1:0] wp_addr;
    logic [DW-1:0] wp_data;
    bit            rp_v, rp_host;
    logic [DW-1:0] rp_data;
    logic [DW-1:0] last_hr;

    bit            exp_gnt, exp_stall, exp_cslt, exp_wrb, exp_hrv, exp_crv;
    logic [AW-1:0] exp_add;
    logic [DW-1:0] exp_bcdt, exp_hrdata, exp_rd;

    task automatic model_clear();
        starve = 0; wp_v = 0; wp_host = 0; wp_addr = '0; wp_data = '0;
        rp_v = 0; rp_host = 0; rp_data = '0; last_hr = '0;
    endtask

    // Expected outputs for the current cycle from the current inputs.
    task automatic eval();
        bit win;
        win = hst_req && (!ps_dm_cslt || starve == SMAX) && !reset;
        exp_gnt   = win;
        exp_stall = win && ps_dm_cslt;
        exp_cslt  = !reset && (win || ps_dm_cslt);
        exp_wrb   = win ? hst_wrb : ps_dm_wrb;
        exp_add   = win ? hst_add : dg_dm_add;
        if (reset) exp_bcdt = '0;
        else       exp_bcdt = (wp_v && wp_host) ? wp_data : bc_dt;
        exp_hrv    = !reset && rp_v && rp_host;
        exp_crv    = !reset && rp_v && !rp_host;
        exp_rd     = rp_data;
        exp_hrdata = reset ? '0 : (exp_hrv ? rp_data : last_hr);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input bit c_cs, input bit c_wr, input logic [AW-1:0] c_add,
                         input logic [DW-1:0] c_dt, input bit h_rq, input bit h_wr,
                         input logic [AW-1:0] h_add, input logic [DW-1:0] h_dt);
        ps_dm_cslt = c_cs; ps_dm_wrb = c_wr; dg_dm_add = c_add; bc_dt = c_dt;
        hst_req = h_rq; hst_wrb = h_wr; hst_add = h_add; hst_wdata = h_dt;
        @(negedge clk);
        eval();
    endtask

    task automatic drive_idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Clock edge: commit the cycle to the reference model.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (wp_v) ref_mem[wp_addr] = exp_bcdt;
            if (exp_hrv) last_hr = rp_data;
            rp_v    = exp_cslt && !exp_wrb;
            rp_host = exp_gnt;
            rp_data = ref_mem[exp_add];
            wp_v    = exp_cslt && exp_wrb;
            wp_host = exp_gnt;
            wp_addr = exp_add;
            wp_data = hst_wdata;
            if (exp_gnt || !hst_req) starve = 0;
            else if (starve < SMAX) starve = starve + 1;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Requests present while in reset must not reach DM.
        drive(1, 1, 3'd2, 4'h5, 1, 1, 3'd4, 4'h9);
        checks++; if (hst_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", hst_gnt); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", core_stall); end
        checks++; if (m_dm_cslt !== 1'b0) begin errors++; $display("FAIL rst_cslt: got %b want 0", m_dm_cslt); end
        checks++; if (m_bc_dt !== 4'h0) begin errors++; $display("FAIL rst_bcdt: got %h want 0", m_bc_dt); end
        checks++; if (hst_rvalid !== 1'b0 || core_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", hst_rvalid, core_rvalid); end
        checks++; if (hst_rdata !== 4'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", hst_rdata); end
        advance();
        mem_load = 1'b0;
        reset = 1'b0;
        drive_idle();
        checks++; if (hst_gnt !== 1'b0 || m_dm_cslt !== 1'b0) begin errors++; $display("FAIL rel_idle: got gnt=%b cslt=%b want 0 0", hst_gnt, m_dm_cslt); end
        advance();
    endtask

    task automatic test_host_wr_rd();
        drive(0, 0, '0, '0, 1, 1, 3'd5, 4'hA);
        checks++; if (hst_gnt !== 1'b1 || core_stall !== 1'b0) begin errors++; $display("FAIL hw_gnt: got gnt=%b stall=%b want 1 0", hst_gnt, core_stall); end
        checks++; if ({m_dm_cslt, m_dm_wrb, m_dm_add} !== {1'b1, 1'b1, 3'd5}) begin errors++; $display("FAIL hw_cmd: got %b %b %0d want 1 1 5", m_dm_cslt, m_dm_wrb, m_dm_add); end
        advance();
        drive(0, 0, '0, 4'h1, 1, 0, 3'd5, 4'h0);
        checks++; if (m_bc_dt !== 4'hA) begin errors++; $display("FAIL hw_data: got %h want a", m_bc_dt); end
        checks++; if (hst_gnt !== 1'b1 || m_dm_wrb !== 1'b0) begin errors++; $display("FAIL hr_gnt: got gnt=%b wrb=%b want 1 0", hst_gnt, m_dm_wrb); end
        advance();
        drive_idle();
        checks++; if (hst_rvalid !== 1'b1 || hst_rdata !== 4'hA) begin errors++; $display("FAIL hr_data: got v=%b d=%h want 1 a", hst_rvalid, hst_rdata); end
        advance();
        drive_idle();
        checks++; if (hst_rvalid !== 1'b0 || hst_rdata !== 4'hA) begin errors++; $display("FAIL hr_hold: got v=%b d=%h want 0 a", hst_rvalid, hst_rdata); end
        advance();
    endtask

    task automatic test_starvation();
        // Core reads every cycle; host holds a read of addr 1 until granted.
        for (int i = 0; i < 8; i++) begin
            drive(i != 7, 0, AW'(i), '0, i != 5, 0, 3'd1, '0);
            checks++; if (hst_gnt !== (i == 4 || i == 7)) begin errors++; $display("FAIL st_gnt[%0d]: got %b want %b", i, hst_gnt, (i == 4 || i == 7)); end
            checks++; if (core_stall !== (i == 4)) begin errors++; $display("FAIL st_stall[%0d]: got %b want %b", i, core_stall, (i == 4)); end
            if (i >= 1 && i <= 7) begin
                checks++; if (core_rvalid !== (i != 5)) begin errors++; $display("FAIL st_crv[%0d]: got %b want %b", i, core_rvalid, (i != 5)); end
            end
            if (i == 5) begin
                checks++; if (hst_rvalid !== 1'b1 || hst_rdata !== pat(1)) begin errors++; $display("FAIL st_hrd: got v=%b d=%h want 1 %h", hst_rvalid, hst_rdata, pat(1)); end
            end
            advance();
        end
        drive_idle();
        advance();
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 3'd2, '0, 1, 0, 3'd3, '0);
        checks++; if (hst_gnt !== 1'b0 || core_stall !== 1'b0) begin errors++; $display("FAIL sc_arb: got gnt=%b stall=%b want 0 0", hst_gnt, core_stall); end
        checks++; if ({m_dm_wrb, m_dm_add} !== {1'b1, 3'd2}) begin errors++; $display("FAIL sc_cmd: got %b %0d want 1 2", m_dm_wrb, m_dm_add); end
        advance();
        drive(0, 0, '0, 4'h7, 1, 0, 3'd3, '0);
        checks++; if (hst_gnt !== 1'b1 || m_dm_add !== 3'd3) begin errors++; $display("FAIL sc_host: got gnt=%b add=%0d want 1 3", hst_gnt, m_dm_add); end
        checks++; if (m_bc_dt !== 4'h7) begin errors++; $display("FAIL sc_wdata: got %h want 7", m_bc_dt); end
        advance();
        drive(0, 0, '0, '0, 1, 0, 3'd2, '0);
        checks++; if (hst_rvalid !== 1'b1 || hst_rdata !== pat(3)) begin errors++; $display("FAIL sc_rd3: got v=%b d=%h want 1 %h", hst_rvalid, hst_rdata, pat(3)); end
        advance();
        drive_idle();
        checks++; if (hst_rdata !== 4'h7) begin errors++; $display("FAIL sc_rd2: got %h want 7", hst_rdata); end
        advance();
    endtask

    task automatic test_bypass();
        drive(0, 0, '0, '0, 1, 1, 3'd6, 4'h3);
        advance();
        drive(1, 0, 3'd6, 4'hE, 0, 0, '0, '0);
        checks++; if (m_bc_dt !== 4'h3 || m_dm_add !== 3'd6 || hst_gnt !== 1'b0) begin errors++; $display("FAIL bp_cmd: got d=%h add=%0d gnt=%b want 3 6 0", m_bc_dt, m_dm_add, hst_gnt); end
        advance();
        drive_idle();
        checks++; if (core_rvalid !== 1'b1 || dm_bc_dt !== 4'h3) begin errors++; $display("FAIL bp_rd: got v=%b d=%h want 1 3", core_rvalid, dm_bc_dt); end
        advance();
    endtask

    task automatic test_reset_mid_write();
        drive(0, 0, '0, '0, 1, 1, 3'd1, 4'hF);
        advance();
        reset = 1'b1;
        drive(0, 0, '0, 4'h9, 0, 0, '0, '0);
        checks++; if (m_dm_cslt !== 1'b0 || m_bc_dt !== 4'h0) begin errors++; $display("FAIL rw_out: got cslt=%b d=%h want 0 0", m_dm_cslt, m_bc_dt); end
        advance();
        reset = 1'b0;
        drive_idle();
        checks++; if ({hst_gnt, core_stall, hst_rvalid, core_rvalid, m_dm_cslt} !== 5'b0 || hst_rdata !== 4'h0) begin errors++; $display("FAIL rw_idle: got %b%b%b%b%b rd=%h want 00000 0", hst_gnt, core_stall, hst_rvalid, core_rvalid, m_dm_cslt, hst_rdata); end
        advance();
        drive(0, 0, '0, '0, 1, 0, 3'd1, '0);
        advance();
        drive_idle();
        checks++; if (hst_rvalid !== 1'b1 || hst_rdata !== pat(1)) begin errors++; $display("FAIL rw_keep: got v=%b d=%h want 1 %h", hst_rvalid, hst_rdata, pat(1)); end
        advance();
    endtask

    task automatic test_random(input int n);
        bit            c_cs = 0, c_wr = 0, h_rq = 0, h_wr = 0, c_hold = 0, h_hold = 0;
        logic [AW-1:0] c_add = '0, h_add = '0;
        logic [DW-1:0] h_dt = '0;
        for (int i = 0; i < n; i++) begin
            if (!c_hold) begin
                c_cs = ($urandom_range(0, 3) != 0); c_wr = $urandom_range(0, 1) == 1; c_add = AW'($urandom_range(0, 7));
            end
            if (!h_hold) begin
                h_rq = ($urandom_range(0, 2) != 0); h_wr = $urandom_range(0, 1) == 1;
                h_add = AW'($urandom_range(0, 7)); h_dt = DW'($urandom_range(0, 15));
            end
            drive(c_cs, c_wr, c_add, DW'($urandom_range(0, 15)), h_rq, h_wr, h_add, h_dt);
            checks++; if (hst_gnt !== exp_gnt || core_stall !== exp_stall) begin errors++; $display("FAIL rnd_arb[%0d]: got gnt=%b stall=%b want %b %b", i, hst_gnt, core_stall, exp_gnt, exp_stall); end
            checks++; if (m_dm_cslt !== exp_cslt) begin errors++; $display("FAIL rnd_cslt[%0d]: got %b want %b", i, m_dm_cslt, exp_cslt); end
            if (exp_cslt) begin
                checks++; if (m_dm_wrb !== exp_wrb || m_dm_add !== exp_add) begin errors++; $display("FAIL rnd_cmd[%0d]: got %b %0d want %b %0d", i, m_dm_wrb, m_dm_add, exp_wrb, exp_add); end
            end
            checks++; if (m_bc_dt !== exp_bcdt) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, m_bc_dt, exp_bcdt); end
            checks++; if (hst_rvalid !== exp_hrv || core_rvalid !== exp_crv) begin errors++; $display("FAIL rnd_rv[%0d]: got %b%b want %b%b", i, hst_rvalid, core_rvalid, exp_hrv, exp_crv); end
            checks++; if (hst_rdata !== exp_hrdata) begin errors++; $display("FAIL rnd_hrd[%0d]: got %h want %h", i, hst_rdata, exp_hrdata); end
            if (exp_crv) begin
                checks++; if (dm_bc_dt !== exp_rd) begin errors++; $display("FAIL rnd_crd[%0d]: got %h want %h", i, dm_bc_dt, exp_rd); end
            end
            c_hold = exp_stall;
            h_hold = h_rq && !exp_gnt;
            advance();
        end
        drive_idle();
        advance();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset    = 1'b1;
        mem_load = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = pat(i);
        model_clear();
        #1;
        test_reset();
        test_host_wr_rd();
        test_starvation();
        test_same_cycle();
        test_bypass();
        test_reset_mid_write();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data-memory port of the `memory` block between two requesters: the core (program sequencer / DAG / bus-connect path) and a host/DMA port used for loading and inspecting DM.
- Core has priority. A starvation counter guarantees the host one slot after STARVE_MAX consecutive denials.
- Sits between the core and `memory` DM inputs. It handles the DM timing contract:
  - read data is valid one cycle after the read command;
  - write data is sampled one cycle after the write command.

Parameters:
- DMA_SIZE, 3, DM address width.
- DMD_SIZE, 4, DM data width.
- STARVE_MAX, 4, consecutive core wins tolerated while the host is requesting (1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps_dm_cslt  in  1  core DM select.
- ps_dm_wrb  in  1  core write(1)/read(0).
- dg_dm_add  in  DMA_SIZE  core DM address.
- bc_dt  in  DMD_SIZE  core write data (core presents it the cycle after its write command).
- core_stall  out  1  core command not accepted this cycle; core holds the command.
- core_rvalid  out  1  dm_bc_dt holds the core's read result.
- hst_req  in  1  host request, held until granted.
- hst_wrb  in  1  host write(1)/read(0).
- hst_add  in  DMA_SIZE  host address.
- hst_wdata  in  DMD_SIZE  host write data, valid together with hst_req.
- hst_gnt  out  1  host command issued this cycle.
- hst_rvalid  out  1  hst_rdata valid.
- hst_rdata  out  DMD_SIZE  host read data.
- m_dm_cslt  out  1  to memory ps_dm_cslt.
- m_dm_wrb  out  1  to memory ps_dm_wrb.
- m_dm_add  out  DMA_SIZE  to memory dg_dm_add.
- m_bc_dt  out  DMD_SIZE  to memory bc_dt.
- dm_bc_dt  in  DMD_SIZE  read data from memory.

Behaviour:
- Arbitration is combinational from the current request inputs plus registered state.
  - host_win = hst_req & (~ps_dm_cslt | starve_cnt==STARVE_MAX).
  - host_win: hst_gnt=1, core_stall=ps_dm_cslt, m_dm_* driven from hst_*.
  - otherwise: hst_gnt=0, core_stall=0, m_dm_* driven from the core inputs (m_dm_cslt=ps_dm_cslt).
- starve_cnt (4 bits) updates each edge:
  - +1 when hst_req & ~host_win, saturating at STARVE_MAX;
  - cleared when host_win or ~hst_req.
- Write-data phase register (wr_pend, wr_host, wdata_q) is set at an edge where a write is issued. wdata_q captures hst_wdata on a host write.
  - Next cycle: m_bc_dt = wr_host ? wdata_q : bc_dt.
  - When no write is pending: m_bc_dt = bc_dt (keeps memory bypass behaviour for core).
- Read-return register (rd_pend, rd_host) is set at an edge where a read is issued.
  - Next cycle: rd_host ? hst_rvalid=1 : core_rvalid=1.
  - hst_rdata = dm_bc_dt when hst_rvalid, else holds its last value.
- Latency:
  - grant is the same cycle as the request;
  - read data is valid 1 cycle after grant;
  - write lands in DM at the end of the cycle after grant.
- Back-to-back issue is allowed every cycle, any mix of owners. The write phase of command n and the address phase of command n+1 overlap without conflict.
- Simultaneous requests with starve_cnt<STARVE_MAX: core wins and starve_cnt increments.
- Host alone: granted immediately; starve_cnt stays 0.
- Reset (any time, including mid-write/mid-read phase) clears to 0:
  - starve_cnt, wr_pend, rd_pend, wr_host, rd_host, wdata_q, hst_rdata;
  - hst_gnt, core_stall, hst_rvalid, core_rvalid.
  - While reset is high, m_dm_cslt=0 and m_bc_dt=0. A pending write is dropped.

Decomposition:
- Shared package dm_pkg:
  - DMA_SIZE/DMD_SIZE defaults;
  - owner encoding OWN_CORE=0 / OWN_HOST=1;
  - STARVE_CNT_W=4.
- One natural sub-module, dm_starve_ctr: saturating counter with inc/clr/limit inputs and at_limit output. The remainder (mux plus phase registers) stays flat in dm_arbiter.

Test Plan:
- Host write add 5 data 4'hA, then host read add 5 (core idle) → hst_gnt same cycles; m_bc_dt=4'hA the cycle after write grant; hst_rvalid 1 cycle after read grant with hst_rdata=4'hA.
- Core reads every cycle with hst_req held high, STARVE_MAX=4 → core wins 4 cycles (starve_cnt 1..4); 5th cycle hst_gnt=1, core_stall=1 for exactly that cycle; starve_cnt back to 0.
- Same-cycle core write add 2 and host read add 3, starve_cnt=0 → core issued, hst_gnt=0, core_stall=0, starve_cnt=1; host granted next cycle when core idle.
- Host write add 6 data 4'h3 then core read add 6 next cycle → m_bc_dt=4'h3 in second cycle; core_rvalid following cycle with dm_bc_dt=4'h3 (bypass).
- Reset asserted the cycle after a host write grant → m_dm_cslt=0, wr_pend cleared, m_bc_dt=0, DM location unchanged; all outputs 0 until the first request after release.
